// File: rtl/pixel_beat_packer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_beat_packer
// Brief    : Packs a sop/eop framed one-pixel-per-clock stream into N_PIX-lane
//            beats tagged with per-lane x and a shared y coordinate.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_beat_packer #(
   parameter int BITS         = 8,
   parameter int N_PIX        = 8,
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480
) (
   input  logic                                    clk,
   input  logic                                    reset_n,
   input  logic [BITS-1:0]                         pix_in,
   input  logic                                    valid_in,
   input  logic                                    sop_in,
   input  logic                                    eop_in,
   output logic                                    module_ready,
   output logic [N_PIX*BITS-1:0]                   pix_out,
   output logic [N_PIX*$clog2(IMAGE_WIDTH)-1:0]    pixel_x,
   output logic [$clog2(IMAGE_HEIGHT)-1:0]         pixel_y,
   output logic                                    valid_out,
   output logic                                    sop_out,
   output logic                                    eop_out,
   input  logic                                    output_ready,
   output logic                                    frame_err
);

   localparam int c_XW = $clog2(IMAGE_WIDTH);
   localparam int c_YW = $clog2(IMAGE_HEIGHT);
   localparam int c_LW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
   localparam logic [c_XW-1:0] c_X_LAST    = c_XW'(IMAGE_WIDTH - N_PIX);
   localparam logic [c_XW-1:0] c_X_STEP    = c_XW'(N_PIX);
   localparam logic [c_YW-1:0] c_Y_LAST    = c_YW'(IMAGE_HEIGHT - 1);
   localparam logic [c_LW-1:0] c_LANE_LAST = c_LW'(N_PIX - 1);

   typedef enum logic [0:0] {S_WAIT_SOP = 1'b0, S_ACTIVE = 1'b1} state_t;

   state_t                r_state;
   logic [c_LW-1:0]       r_lane;
   logic [c_XW-1:0]       r_x_base;
   logic [c_YW-1:0]       r_y;
   logic [N_PIX*BITS-1:0] r_acc;
   logic                  r_acc_full;
   logic [c_XW-1:0]       r_acc_x;
   logic [c_YW-1:0]       r_acc_y;
   logic                  r_acc_sop;
   logic                  r_acc_eop;

   logic                  w_accept;
   logic                  w_in_frame;
   logic                  w_restart;
   logic                  w_out_free;
   logic [c_LW-1:0]       w_lane;
   logic [c_XW-1:0]       w_x;
   logic [c_YW-1:0]       w_y;
   logic                  w_lane_last;
   logic                  w_frame_last;
   logic                  w_beat_done;
   logic                  w_err;
   logic                  w_ld_acc;
   logic                  w_ld_new;
   logic [N_PIX*BITS-1:0] w_acc;
   logic [N_PIX*BITS-1:0] w_src_pix;
   logic [c_XW-1:0]       w_src_x;
   logic [c_YW-1:0]       w_src_y;
   logic                  w_src_sop;
   logic                  w_src_eop;

   // A frame-end beat can still be parked in the accumulator after returning
   // to S_WAIT_SOP, so readiness always follows acc_full.
   assign module_ready = reset_n && !r_acc_full;
   assign w_accept     = valid_in && module_ready;
   assign w_in_frame   = w_accept && (sop_in || (r_state == S_ACTIVE));
   assign w_restart    = w_accept && sop_in && (r_state == S_ACTIVE);
   assign w_out_free   = !valid_out || output_ready;

   // sop always lands in lane 0 of a fresh frame origin
   assign w_lane       = sop_in ? '0 : r_lane;
   assign w_x          = sop_in ? '0 : r_x_base;
   assign w_y          = sop_in ? '0 : r_y;
   assign w_lane_last  = (w_lane == c_LANE_LAST);
   assign w_frame_last = w_lane_last && (w_x == c_X_LAST) && (w_y == c_Y_LAST);
   assign w_beat_done  = w_lane_last || eop_in;
   assign w_err        = w_restart || (w_in_frame && w_beat_done && (w_frame_last != eop_in));

   assign w_ld_acc     = r_acc_full && w_out_free;
   assign w_ld_new     = w_in_frame && w_beat_done && w_out_free;

   always_comb begin
      w_acc = (w_lane == '0) ? '0 : r_acc;
      for (int i = 0; i < N_PIX; i++) begin
         if (w_lane == c_LW'(i)) begin
            w_acc[i*BITS +: BITS] = pix_in;
         end
      end
   end

   assign w_src_pix = w_ld_acc ? r_acc     : w_acc;
   assign w_src_x   = w_ld_acc ? r_acc_x   : w_x;
   assign w_src_y   = w_ld_acc ? r_acc_y   : w_y;
   assign w_src_sop = w_ld_acc ? r_acc_sop : ((w_x == '0) && (w_y == '0));
   assign w_src_eop = w_ld_acc ? r_acc_eop : (eop_in || w_frame_last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_WAIT_SOP;
         r_lane     <= '0;
         r_x_base   <= '0;
         r_y        <= '0;
         r_acc      <= '0;
         r_acc_full <= 1'b0;
         r_acc_x    <= '0;
         r_acc_y    <= '0;
         r_acc_sop  <= 1'b0;
         r_acc_eop  <= 1'b0;
         pix_out    <= '0;
         pixel_x    <= '0;
         pixel_y    <= '0;
         valid_out  <= 1'b0;
         sop_out    <= 1'b0;
         eop_out    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= w_err;

         if (w_ld_acc || w_ld_new) begin
            valid_out <= 1'b1;
            pix_out   <= w_src_pix;
            pixel_y   <= w_src_y;
            sop_out   <= w_src_sop;
            eop_out   <= w_src_eop;
            for (int i = 0; i < N_PIX; i++) begin
               pixel_x[i*c_XW +: c_XW] <= w_src_x + c_XW'(i);
            end
         end else if (output_ready) begin
            valid_out <= 1'b0;
         end

         if (w_in_frame) begin
            r_acc <= w_acc;
         end

         // Completed beat that cannot reach the output yet is parked here
         if (w_ld_acc) begin
            r_acc_full <= 1'b0;
         end else if (w_in_frame && w_beat_done && !w_out_free) begin
            r_acc_full <= 1'b1;
            r_acc_x    <= w_x;
            r_acc_y    <= w_y;
            r_acc_sop  <= (w_x == '0) && (w_y == '0);
            r_acc_eop  <= eop_in || w_frame_last;
         end

         if (w_in_frame) begin
            if (w_beat_done) begin
               r_lane <= '0;
               if (eop_in || w_frame_last) begin
                  r_state  <= S_WAIT_SOP;
                  r_x_base <= '0;
                  r_y      <= '0;
               end else begin
                  r_state <= S_ACTIVE;
                  if (w_x == c_X_LAST) begin
                     r_x_base <= '0;
                     r_y      <= w_y + 1'b1;
                  end else begin
                     r_x_base <= w_x + c_X_STEP;
                     r_y      <= w_y;
                  end
               end
            end else begin
               r_state  <= S_ACTIVE;
               r_lane   <= w_lane + 1'b1;
               r_x_base <= w_x;
               r_y      <= w_y;
            end
         end
      end
   end

endmodule
`default_nettype wire
